// File: rtl/tick_interval_meter_pkg.sv
// Shared constants for the tick interval meter: FSM state encoding, default
// width, and overflow bit positions (also used by the countdown timer).
package tick_interval_meter_pkg;

  localparam int unsigned TIM_DEFAULT_W = 32;

  localparam int unsigned OVF_SAT = 1;
  localparam int unsigned OVF_CNT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } tim_state_e;

endpackage

// File: rtl/tick_interval_meter_sat_counter.sv
// W-bit saturating up-counter with synchronous clear, enable and a sticky
// saturated flag. nxt_o is the value the counter takes on this edge if enabled.
module tick_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] nxt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_comb begin
    sat_d = sat_q;
    if (clr_i)                      sat_d = 1'b0;
    else if (en_i && cnt_d == '1)   sat_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= clr_i ? '0 : cnt_d;
      sat_q <= sat_d;
    end
  end

  assign nxt_o = cnt_d;
  assign sat_o = sat_q;

endmodule

// File: rtl/tick_interval_meter.sv
// Tick interval meter: counts timer_tick between start and stop, holds the
// result under a valid/ack handshake. Optional auto-stop: TICK_INTERVAL_TIMEOUT_EN.
import tick_interval_meter_pkg::*;

module tick_interval_meter #(
  parameter int unsigned W = TIM_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         stop,
  input  logic         timer_tick,
  input  logic         ack,
`ifdef TICK_INTERVAL_TIMEOUT_EN
  input  logic [W-1:0] limit,
  output logic         timed_out,
`endif
  output logic [W-1:0] count,
  output logic         valid,
  output logic         busy,
  output logic [1:0]   overflow
);

  tim_state_e   state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         to_q, to_d;
  logic         clr, tick_acc;
  logic [W-1:0] cnt_nxt;
  logic         sat;

  tick_sat_counter #(.W(W)) u_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (clr),
    .en_i  (tick_acc),
    .nxt_o (cnt_nxt),
    .sat_o (sat)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    to_d     = to_q;
    clr      = 1'b0;
    tick_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COUNT;
          clr     = 1'b1;
          to_d    = 1'b0;
        end
      end
      ST_COUNT: begin
        if (start) begin
          clr  = 1'b1;
          to_d = 1'b0;
        end else begin
          tick_acc = timer_tick;
          // cnt_nxt already folds in a tick coincident with stop
          if (stop) begin
            state_d = ST_HOLD;
            count_d = cnt_nxt;
          end
`ifdef TICK_INTERVAL_TIMEOUT_EN
          if (tick_acc && (limit != '0) && (cnt_nxt == limit)) begin
            state_d = ST_HOLD;
            count_d = limit;
            to_d    = 1'b1;
          end
`endif
        end
      end
      ST_HOLD: begin
        if (ack) begin
          if (start) begin
            state_d = ST_COUNT;
            clr     = 1'b1;
            to_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      to_q    <= to_d;
    end
  end

  assign count             = count_q;
  assign valid             = (state_q == ST_HOLD);
  assign busy              = (state_q == ST_COUNT);
  assign overflow[OVF_SAT] = sat;
  assign overflow[OVF_CNT] = tick_acc;

`ifdef TICK_INTERVAL_TIMEOUT_EN
  assign timed_out = to_q;
`else
  logic unused_to;
  assign unused_to = to_q;
`endif

endmodule

// File: tb/tb_tick_interval_meter.sv
// Directed self-checking bench for tick_interval_meter (W=32 and W=4 instances
// share stimulus). Timeout scenario built when TICK_INTERVAL_TIMEOUT_EN is defined.
module tb_tick_interval_meter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0, stop = 1'b0, timer_tick = 1'b0, ack = 1'b0;
  logic [31:0] count;
  logic        valid, busy;
  logic [1:0]  overflow;
  logic [3:0]  count4;
  logic        valid4, busy4;
  logic [1:0]  overflow4;
`ifdef TICK_INTERVAL_TIMEOUT_EN
  logic [31:0] limit = '0;
  logic [3:0]  limit4 = '0;
  logic        timed_out, timed_out4;
`endif

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  tick_interval_meter #(.W(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .timer_tick(timer_tick), .ack(ack),
`ifdef TICK_INTERVAL_TIMEOUT_EN
    .limit(limit), .timed_out(timed_out),
`endif
    .count(count), .valid(valid), .busy(busy), .overflow(overflow)
  );

  tick_interval_meter #(.W(4)) dut4 (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .timer_tick(timer_tick), .ack(ack),
`ifdef TICK_INTERVAL_TIMEOUT_EN
    .limit(limit4), .timed_out(timed_out4),
`endif
    .count(count4), .valid(valid4), .busy(busy4), .overflow(overflow4)
  );

  task automatic cyc(input logic s, input logic p, input logic t, input logic a);
    start = s; stop = p; timer_tick = t; ack = a;
    @(posedge clk); #1;
    start = 0; stop = 0; timer_tick = 0; ack = 0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(0, 0, 1, 0);
  endtask

  task automatic test_reset;
    #1;
    total++; if ({count, valid, busy, overflow} !== 36'd0) $display("FAIL reset_outputs got count=%0d valid=%b busy=%b ovf=%b want all 0", count, valid, busy, overflow); else passed++;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    cyc(1, 0, 0, 0);
    total++; if (busy !== 1'b1 || valid !== 1'b0) $display("FAIL basic_busy got busy=%b valid=%b want 1 0", busy, valid); else passed++;
    for (int unsigned i = 0; i < 5; i++) begin
      timer_tick = 1'b1; #1;
      if (i == 0) begin
        total++; if (overflow !== 2'b01) $display("FAIL basic_tick_flag got %b want 01", overflow); else passed++;
      end
      @(posedge clk); #1; timer_tick = 1'b0;
      cyc(0, 0, 0, 0);
    end
    total++; if (valid !== 1'b0) $display("FAIL basic_valid_early got %b want 0", valid); else passed++;
    cyc(0, 1, 0, 0);
    total++; if (count !== 32'd5 || valid !== 1'b1 || busy !== 1'b0 || overflow !== 2'b00)
      $display("FAIL basic_result got count=%0d valid=%b busy=%b ovf=%b want 5 1 0 00", count, valid, busy, overflow); else passed++;
    cyc(0, 0, 0, 1);
    total++; if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_ack got valid=%b busy=%b want 0 0", valid, busy); else passed++;
  endtask

  task automatic test_stop_with_tick;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    total++; if (count !== 32'd3 || valid !== 1'b1) $display("FAIL stop_tick got count=%0d valid=%b want 3 1", count, valid); else passed++;
    cyc(0, 0, 0, 1);
    total++; if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL stop_tick_ack got valid=%b busy=%b want 0 0", valid, busy); else passed++;
  endtask

  task automatic test_saturation;
    cyc(1, 0, 0, 0);
    ticks(20);
    cyc(0, 1, 0, 0);
    total++; if (count4 !== 4'd15 || overflow4 !== 2'b10) $display("FAIL sat_w4 got count=%0d ovf=%b want 15 10", count4, overflow4); else passed++;
    total++; if (count !== 32'd20 || overflow !== 2'b00) $display("FAIL sat_w32 got count=%0d ovf=%b want 20 00", count, overflow); else passed++;
    cyc(0, 0, 0, 0);
    total++; if (overflow4 !== 2'b10 || count4 !== 4'd15) $display("FAIL sat_hold got count=%0d ovf=%b want 15 10", count4, overflow4); else passed++;
    cyc(0, 0, 0, 1);
    total++; if (overflow4[1] !== 1'b1) $display("FAIL sat_idle_keep got %b want 1", overflow4[1]); else passed++;
    cyc(1, 0, 0, 0);
    total++; if (overflow4 !== 2'b00 || busy4 !== 1'b1) $display("FAIL sat_clear got ovf=%b busy=%b want 00 1", overflow4, busy4); else passed++;
    cyc(0, 1, 0, 0);
    total++; if (count !== 32'd0 || valid !== 1'b1) $display("FAIL zero_ticks got count=%0d valid=%b want 0 1", count, valid); else passed++;
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_restart;
    cyc(1, 0, 0, 0);
    ticks(4);
    cyc(1, 0, 1, 0);
    ticks(2);
    cyc(1, 1, 0, 0);
    total++; if (busy !== 1'b1 || valid !== 1'b0) $display("FAIL restart_prio got busy=%b valid=%b want 1 0", busy, valid); else passed++;
    ticks(2);
    cyc(0, 1, 0, 0);
    total++; if (count !== 32'd2 || valid !== 1'b1) $display("FAIL restart_count got count=%0d valid=%b want 2 1", count, valid); else passed++;
    cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 0);
    total++; if (busy !== 1'b1 || valid !== 1'b0) $display("FAIL idle_start_stop got busy=%b valid=%b want 1 0", busy, valid); else passed++;
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_back_to_back;
    ticks(1);
    cyc(1, 0, 0, 0);
    total++; if (valid !== 1'b1 || busy !== 1'b0 || count !== 32'd0) $display("FAIL hold_start_ignored got count=%0d valid=%b busy=%b want 0 1 0", count, valid, busy); else passed++;
    cyc(1, 0, 0, 1);
    total++; if (busy !== 1'b1 || valid !== 1'b0) $display("FAIL ack_start got busy=%b valid=%b want 1 0", busy, valid); else passed++;
    ticks(2);
    cyc(0, 1, 0, 0);
    total++; if (count !== 32'd2) $display("FAIL ack_start_count got %0d want 2", count); else passed++;
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_reset_mid;
    cyc(1, 0, 0, 0);
    ticks(7);
    rstn = 1'b0; #1;
    total++; if ({count, valid, busy, overflow} !== 36'd0) $display("FAIL reset_mid got count=%0d valid=%b busy=%b ovf=%b want all 0", count, valid, busy, overflow); else passed++;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    cyc(0, 1, 0, 0);
    total++; if (valid !== 1'b0 || busy !== 1'b0 || count !== 32'd0) $display("FAIL reset_stop_ignored got count=%0d valid=%b busy=%b want 0 0 0", count, valid, busy); else passed++;
  endtask

`ifdef TICK_INTERVAL_TIMEOUT_EN
  task automatic test_timeout;
    limit = 32'd3;
    cyc(1, 0, 0, 0);
    ticks(10);
    total++; if (count !== 32'd3 || timed_out !== 1'b1 || valid !== 1'b1) $display("FAIL timeout got count=%0d to=%b valid=%b want 3 1 1", count, timed_out, valid); else passed++;
    cyc(1, 0, 0, 1);
    total++; if (timed_out !== 1'b0 || busy !== 1'b1) $display("FAIL timeout_clear got to=%b busy=%b want 0 1", timed_out, busy); else passed++;
    ticks(2);
    cyc(0, 1, 1, 0);
    total++; if (count !== 32'd3 || timed_out !== 1'b1) $display("FAIL timeout_stop got count=%0d to=%b want 3 1", count, timed_out); else passed++;
    cyc(0, 0, 0, 1);
    limit = '0;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_stop_with_tick;
    test_saturation;
    test_restart;
    test_back_to_back;
    test_reset_mid;
`ifdef TICK_INTERVAL_TIMEOUT_EN
    test_timeout;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tick_interval_meter.md
Name: tick_interval_meter

Overview:
- Measuring end of the tick-driven countdown timer.
- Counts `timer_tick` pulses between a `start` and a `stop` strobe, then presents the measured interval. The interval can be loaded straight back into the timer as its N.
- Result is held with a valid/ack handshake to the register bank.
- Sits beside the countdown timer on the same `timer_tick` source.

Parameters:
- `W`, 32, width of the tick counter and of the result.

Ports:
- `clk`  input  1  system clock, all logic on rising edge.
- `rstn`  input  1  asynchronous active-low reset.
- `start`  input  1  one-cycle strobe: clear counter and begin counting.
- `stop`  input  1  one-cycle strobe: end measurement and latch result.
- `timer_tick`  input  1  single-cycle tick enable to be counted.
- `ack`  input  1  consumer has read the result; releases HOLD.
- `count`  output  W  latched interval, in ticks.
- `valid`  output  1  `count` holds a fresh, unread result.
- `busy`  output  1  high while in COUNT.
- `overflow`  output  2  {saturated, counting}:
  - bit1: counter reached all-ones during this measurement.
  - bit0: a tick was accepted this cycle.

Behaviour:
- Reset values (async, `rstn`=0):
  - state=IDLE
  - internal counter=0, `count`=0
  - `valid`=0, `busy`=0, `overflow`=2'b00
- Reset mid-measurement discards everything; no partial result is emitted.
- States: IDLE, COUNT, HOLD.
- IDLE:
  - `start` -> COUNT; counter:=0, saturated:=0.
  - `stop` and `ack` are ignored.
- COUNT:
  - `busy`=1.
  - On `timer_tick`: counter:=counter+1, saturating at 2^W-1; saturated:=1 when the value becomes all-ones.
  - `overflow[0]`=1 in any cycle where a tick was accepted, including a saturated tick.
  - `start` in COUNT restarts: counter:=0, saturated:=0, stay in COUNT. A tick in the same cycle is dropped.
  - `stop` -> HOLD:
    - `count`:=counter, plus 1 if `timer_tick` is high in the same cycle (saturating).
    - `valid`:=1 on the next cycle (registered, 1-cycle latency).
  - `start` and `stop` in the same cycle: `start` wins.
- HOLD:
  - `valid`=1, `count` stable, `busy`=0.
  - `overflow[1]` keeps the saturated flag until the next `start`.
  - `ack` -> IDLE, `valid`:=0 next cycle.
  - `ack` and `start` in the same cycle -> COUNT directly (counter cleared, `valid`:=0).
  - `start` without `ack` is ignored; a result is never overwritten unread.
- Arithmetic: unsigned, W bits, no wrap-around; saturation replaces wrap.
- A measurement with zero ticks gives `count`=0 with `valid`=1.

Optional Feature:
- Macro `TICK_INTERVAL_TIMEOUT_EN`.
- Defined:
  - Adds input `limit` [W-1:0] and output `timed_out` (1 bit).
  - In COUNT, when an accepted tick makes counter == `limit` (`limit`≠0), auto-stop: `count`:=`limit`, go to HOLD, `timed_out`:=1.
  - `timed_out` clears on the next `start`.
  - `limit`=0 disables the timeout.
  - An explicit `stop` in the same cycle gives the same result with `timed_out`=1.
- Undefined: no `limit`/`timed_out` ports; measurement ends only on `stop`.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'd0, COUNT=2'd1, HOLD=2'd2)
  - default width constant (32)
  - `overflow` bit index constants (SAT=1, CNT=0), shared with the countdown timer.
- Natural sub-module: `tick_sat_counter`, a W-bit saturating up-counter with clear/enable and a saturated flag.
- FSM and handshake stay in the top.

Test Plan:
- Basic measurement: `start`; 5 isolated ticks; `stop` with no tick -> `count`=5, `valid`=1 one cycle after `stop`, `busy` 1->0, `overflow`=2'b00 in HOLD.
- `stop` coincident with the 3rd tick -> `count`=3. Then `ack` -> `valid`=0 next cycle, state IDLE.
- Saturation: `W`=4; `start`; 20 ticks; `stop` -> `count`=15, `overflow[1]`=1 through HOLD, cleared by the next `start`.
- Handshake:
  - `start` in HOLD without `ack` -> ignored, `count` unchanged.
  - `ack`+`start` together -> `busy`=1 next cycle, `valid`=0; 2 ticks + `stop` -> `count`=2.
- Restart/priority:
  - `start`, 4 ticks, `start`, 2 ticks, `stop` -> `count`=2.
  - `start`+`stop` in the same cycle from IDLE -> enters COUNT, `valid` stays 0.
- Reset: `rstn` low mid-COUNT after 7 ticks -> all outputs 0 immediately; after release `stop` is ignored and `valid` stays 0. With `TICK_INTERVAL_TIMEOUT_EN`: `limit`=3, 10 ticks -> `count`=3, `timed_out`=1.
